// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset vector, fetch FSM states, NPC operation
// encodings and the {pc, instr} word carried between fetch and decode.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HELD  = 2'd1,
    S_ERR   = 2'd2
  } fetch_state_e;

  // Encodings shared with NPC and the control unit.
  typedef enum logic [1:0] {
    NPC_OTHER = 2'd0,
    NPC_BEQ   = 2'd1,
    NPC_JAL_J = 2'd2,
    NPC_JR    = 2'd3
  } npc_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry {pc, instr} buffer that parks a completed fetch while decode is stalled.
module fetch_skid
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  fetch_word_t din,
  output logic        valid,
  output fetch_word_t dout
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns PC_F, runs the imem request/ready handshake and loads the
// F/D register, applying stalls and decode-resolved redirects with delay-slot semantics.
//
// state   | meaning
// S_FETCH | request outstanding at PC_F
// S_HELD  | fetched word parked in the skid buffer, waiting for decode
// S_ERR   | misaligned fetch target seen; halted until reset
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] PC_D,
  output logic [31:0] Instr_D,
  output logic        valid_D,
  output logic        addr_err
);

  fetch_state_e state;
  logic         pend_v;
  logic [31:0]  pend_tgt;
  logic         complete;
  logic         load_ok;
  logic         consumed;
  logic         redir;
  logic [31:0]  next_pc;
  logic         next_bad;
  logic         skid_load;
  logic         skid_unload;
  logic         skid_valid;
  fetch_word_t  skid_in;
  fetch_word_t  skid_out;

  assign imem_req  = (state == S_FETCH) && !reset;
  assign imem_addr = PC_F;
  assign complete  = imem_req && imem_ready;
  assign load_ok   = !(valid_D && stall);
  assign consumed  = valid_D && !stall;
  assign redir     = redirect_valid && consumed;
  assign next_pc   = redir  ? redirect_target :
                     pend_v ? pend_tgt        :
                              PC_F + 32'd4;
  assign next_bad  = misaligned(next_pc);

  assign skid_in.pc    = PC_F;
  assign skid_in.instr = imem_rdata;
  assign skid_load     = (state == S_FETCH) && complete && !load_ok && !next_bad;
  assign skid_unload   = (state == S_HELD) && load_ok;

  fetch_skid u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .din    (skid_in),
    .valid  (skid_valid),
    .dout   (skid_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      PC_F     <= RESET_PC;
      PC_D     <= '0;
      Instr_D  <= '0;
      valid_D  <= 1'b0;
      addr_err <= 1'b0;
      pend_v   <= 1'b0;
      pend_tgt <= '0;
    end else begin
      // A redirect with no fetch finishing this cycle waits for the delay slot.
      if (redir && !complete) begin
        pend_v   <= 1'b1;
        pend_tgt <= redirect_target;
      end
      case (state)
        S_FETCH: begin
          if (complete) begin
            if (load_ok) begin
              PC_D    <= PC_F;
              Instr_D <= imem_rdata;
              valid_D <= 1'b1;
            end
            if (next_bad) begin
              addr_err <= 1'b1;
              state    <= S_ERR;
            end else begin
              PC_F   <= next_pc;
              pend_v <= 1'b0;
              if (!load_ok) state <= S_HELD;
            end
          end else if (consumed) begin
            valid_D <= 1'b0;
          end
        end
        S_HELD: begin
          if (load_ok) begin
            if (skid_valid) begin
              PC_D    <= skid_out.pc;
              Instr_D <= skid_out.instr;
              valid_D <= 1'b1;
            end else if (consumed) begin
              valid_D <= 1'b0;
            end
            state <= S_FETCH;
          end
        end
        S_ERR: begin
          if (consumed) valid_D <= 1'b0;
        end
        default: state <= S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded random bench for fetch_sequencer against a queue-level model of the
// fetch stream (decode + parking slot seen as a two-deep instruction queue).
module tb_fetch_sequencer;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_f;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        addr_err;
  logic        done_flag = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .PC_F            (pc_f),
    .PC_D            (pc_d),
    .Instr_D         (instr_d),
    .valid_D         (valid_d),
    .addr_err        (addr_err)
  );

  typedef struct packed {
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        vd;
    logic [31:0] pcd;
    logic [31:0] instr;
    logic        err;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: fetch address, pending redirect, halt flag, and the ordered
  // list of fetched words not yet retired from decode (front = word in decode).
  logic [31:0] m_pc;
  logic        m_pend_v;
  logic [31:0] m_pend_tgt;
  logic        m_err;
  logic        m_known = 1'b0;
  logic [63:0] m_dq[$];
  logic [63:0] m_dlast;
  int          err_cycles = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h2400_0000;
  endfunction

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_pc     = RST_PC;
    m_pend_v = 1'b0;
    m_pend_tgt = '0;
    m_err    = 1'b0;
    m_dq.delete();
    m_dlast  = '0;
    m_known  = 1'b1;
  endtask

  task automatic cycle(input logic rst, input logic stl, input logic rv,
                       input logic [31:0] tgt, input logic rdy);
    obs_t        e;
    logic        done, consume, take, load_ok, bad;
    logic [31:0] nxt;
    logic [63:0] w;
    @(posedge clk);
    #1;
    reset           = rst;
    stall           = stl;
    redirect_valid  = rv;
    redirect_target = tgt;
    imem_ready      = rdy;
    imem_rdata      = mem_word(m_pc);

    e.chk   = m_known;
    e.req   = !rst && !m_err && (m_dq.size() < 2);
    e.addr  = m_pc;
    e.vd    = m_dq.size() > 0;
    w       = e.vd ? m_dq[0] : m_dlast;
    e.pcd   = w[63:32];
    e.instr = w[31:0];
    e.err   = m_err;
    exp_q.push_back(e);

    if (rst) begin
      model_reset();
    end else begin
      done    = e.req && rdy;
      consume = e.vd && !stl;
      load_ok = !(e.vd && stl);
      take    = rv && consume;
      nxt     = take ? tgt : (m_pend_v ? m_pend_tgt : m_pc + 32'd4);
      bad     = nxt[1:0] != 2'b00;
      w       = {m_pc, mem_word(m_pc)};
      if (consume) m_dlast = m_dq.pop_front();
      if (done) begin
        if (bad) begin
          m_err = 1'b1;
          if (load_ok) m_dq.push_back(w);
        end else begin
          m_dq.push_back(w);
          m_pc     = nxt;
          m_pend_v = 1'b0;
        end
      end else if (take) begin
        m_pend_v   = 1'b1;
        m_pend_tgt = tgt;
      end
    end
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          tests++;
          if (imem_req !== e.req || imem_addr !== e.addr || pc_f !== e.addr ||
              valid_d !== e.vd || pc_d !== e.pcd || instr_d !== e.instr ||
              addr_err !== e.err) begin
            fails++;
            $display("FAIL cycle_obs t=%0t got req=%b addr=%h pcf=%h vd=%b pcd=%h instr=%h err=%b want req=%b addr=%h vd=%b pcd=%h instr=%h err=%b",
                     $time, imem_req, imem_addr, pc_f, valid_d, pc_d, instr_d, addr_err,
                     e.req, e.addr, e.vd, e.pcd, e.instr, e.err);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    if (!done_flag) begin
      fails++;
      $display("FAIL timeout t=%0t stimulus did not finish", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin : stimulus
    logic        rst, stl, rv, rdy;
    logic [31:0] tgt;
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    check_val("reset_pc_f",     pc_f,             RST_PC);
    check_val("reset_pc_d",     pc_d,             32'h0);
    check_val("reset_instr_d",  instr_d,          32'h0);
    check_val("reset_valid_d",  {31'h0, valid_d}, 32'h0);
    check_val("reset_addr_err", {31'h0, addr_err}, 32'h0);
    check_val("reset_imem_req", {31'h0, imem_req}, 32'h0);
    // Straight-line fetch.
    repeat (4) cycle(0, 0, 0, 0, 1);
    // Stall with memory ready, then release.
    repeat (3) cycle(0, 1, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);
    // Redirect while the delay slot completes.
    cycle(0, 0, 1, 32'h0000_3100, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);
    // Redirect while memory is not ready.
    cycle(0, 0, 1, 32'h0000_3200, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 1);
    // Redirect to the top of the address space to exercise PC wrap.
    cycle(0, 0, 1, 32'hFFFF_FFF8, 1);
    repeat (4) cycle(0, 0, 0, 0, 1);
    // Misaligned target halts fetch; decode drains; reset recovers.
    cycle(0, 0, 1, 32'h0000_3102, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 1);
    // Reset in the middle of an outstanding request.
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      err_cycles = m_err ? err_cycles + 1 : 0;
      rst = ($urandom_range(0, 199) == 0) || (err_cycles > 6);
      stl = $urandom_range(0, 99) < 30;
      rv  = $urandom_range(0, 99) < 20;
      rdy = $urandom_range(0, 99) < 70;
      tgt = {16'h0000, 16'($urandom_range(0, 16'hFFFF))} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 29) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 49) == 0) tgt = 32'hFFFF_FFFC;
      cycle(rst, stl, rv, tgt, rdy);
    end
    cycle(0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    done_flag = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
